// File: rtl/led_chain_driver.sv
// led_chain_driver: serial driver for a chain of WS281x-style addressable LEDs.
// Holds one 24-bit RGB colour per LED in a small write-anytime RAM. On a frame
// request it streams every LED as {G,R,B}, MSB first, scaled by a global
// brightness. The frame ends with a latch-low period and a one-cycle done pulse.
//
// Ports:
//   i_Clock        clock, all logic on the rising edge
//   i_Reset        asynchronous active-high reset
//   i_Wr_En        colour RAM write strobe
//   i_Wr_Addr      LED index to write (out-of-range writes are dropped)
//   i_Wr_Data      colour {R[23:16], G[15:8], B[7:0]}
//   i_Brightness   global brightness, latched at frame start
//   i_Start        frame request, honoured only while idle
//   o_Led          serial data line to the first LED
//   o_Ready        high while idle and able to accept i_Start
//   o_Frame_Done   one-cycle pulse on the last cycle of the latch period
module led_chain_driver #(
    parameter int unsigned CLOCK_FREQUENCY = 80000000,
    parameter int unsigned NUM_LEDS        = 8,
    parameter int unsigned T0H_NS          = 400,
    parameter int unsigned T1H_NS          = 800,
    parameter int unsigned BIT_NS          = 1250,
    parameter int unsigned LATCH_US        = 80,
    localparam int unsigned ADDR_W         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_En,
    input  logic [ADDR_W-1:0] i_Wr_Addr,
    input  logic [23:0]       i_Wr_Data,
    input  logic [7:0]        i_Brightness,
    input  logic              i_Start,
    output logic              o_Led,
    output logic              o_Ready,
    output logic              o_Frame_Done
);

    // Cycle counts, computed in 64 bits so CLOCK_FREQUENCY*ns cannot overflow.
    localparam longint unsigned CLK64   = 64'(CLOCK_FREQUENCY);
    localparam int unsigned     N_T0H   = 32'((CLK64 * 64'(T0H_NS)) / 64'd1000000000);
    localparam int unsigned     N_T1H   = 32'((CLK64 * 64'(T1H_NS)) / 64'd1000000000);
    localparam int unsigned     N_BIT   = 32'((CLK64 * 64'(BIT_NS)) / 64'd1000000000);
    localparam int unsigned     N_LATCH = (CLOCK_FREQUENCY / 1000000) * LATCH_US;
    localparam int unsigned     CNT_MAX = (N_BIT > N_LATCH) ? N_BIT : N_LATCH;
    localparam int unsigned     CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned     LAST_IDX = NUM_LEDS - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         bit_q, bit_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [23:0]        shift_q, shift_d;
    logic [7:0]         bright_q, bright_d;
    logic               led_q, led_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    logic [23:0]        color_ram [NUM_LEDS];
    logic               wr_ok;
    logic [23:0]        rd_word;
    logic [8:0]         bright_p1;
    logic [16:0]        prod_r, prod_g, prod_b;
    logic [CNT_W-1:0]   hi_len;
    logic [CNT_W-1:0]   low_len;
    logic [CNT_W-1:0]   low_end;
    logic               last_led;

    // Colour RAM: no reset so it can map onto a memory macro.
    assign wr_ok = i_Wr_En && (32'(i_Wr_Addr) < NUM_LEDS);

    always_ff @(posedge i_Clock) begin
        if (wr_ok) begin
            color_ram[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    // Read with write-first bypass so a same-cycle write reaches the LOAD.
    always_comb begin
        rd_word = color_ram[idx_q];
        if (wr_ok && (i_Wr_Addr == idx_q)) begin
            rd_word = i_Wr_Data;
        end
    end

    // Brightness scaling: c * (B+1) >> 8, truncated.
    always_comb begin
        bright_p1 = {1'b0, bright_q} + 9'd1;
        prod_r    = {9'b0, rd_word[23:16]} * {8'b0, bright_p1};
        prod_g    = {9'b0, rd_word[15:8]}  * {8'b0, bright_p1};
        prod_b    = {9'b0, rd_word[7:0]}   * {8'b0, bright_p1};
    end

    // Bit timing for the bit currently at the top of the shift word.
    always_comb begin
        hi_len   = shift_q[23] ? CNT_W'(N_T1H) : CNT_W'(N_T0H);
        low_len  = CNT_W'(N_BIT) - hi_len;
        last_led = (idx_q == ADDR_W'(LAST_IDX));
        // Last bit of a non-final LED gives one low cycle to the following LOAD.
        if ((bit_q == 5'd0) && !last_led) begin
            low_end = low_len - CNT_W'(2);
        end else begin
            low_end = low_len - CNT_W'(1);
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        bright_d = bright_q;

        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    state_d  = S_LOAD;
                    idx_d    = '0;
                    cnt_d    = '0;
                    bright_d = i_Brightness;
                end
            end
            S_LOAD: begin
                shift_d = {prod_g[15:8], prod_r[15:8], prod_b[15:8]};
                bit_d   = 5'd23;
                cnt_d   = '0;
                state_d = S_HIGH;
            end
            S_HIGH: begin
                if (cnt_q == hi_len - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOW: begin
                if (cnt_q == low_end) begin
                    cnt_d = '0;
                    if (bit_q != 5'd0) begin
                        shift_d = {shift_q[22:0], 1'b0};
                        bit_d   = bit_q - 5'd1;
                        state_d = S_HIGH;
                    end else if (last_led) begin
                        state_d = S_LATCH;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LATCH: begin
                if (cnt_q == CNT_W'(N_LATCH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the state being entered so they are registered in phase.
        led_d   = (state_d == S_HIGH);
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_LATCH) && (cnt_d == CNT_W'(N_LATCH - 1));
    end

    // State and control registers.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            bright_q <= 8'hFF;
            led_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            bright_q <= bright_d;
            led_q    <= led_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign o_Led        = led_q;
    assign o_Ready      = ready_q;
    assign o_Frame_Done = done_q;

endmodule

// File: tb/tb_led_chain_driver.sv
// Testbench for led_chain_driver: a wire decoder turns o_Led back into 24-bit
// words and checks them against expected words queued when each frame starts.
module tb_led_chain_driver;

    // 20 MHz, 3 LEDs, 10 us latch: T0H=8, T1H=16, BIT=25, LATCH=200 cycles.
    localparam int unsigned NL    = 3;
    localparam int unsigned AW    = 2;
    localparam int          T0H   = 8;
    localparam int          T1H   = 16;
    localparam int          BITC  = 25;
    localparam int          LATCH = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic [7:0]    bright;
    logic          start;
    logic          led;
    logic          ready;
    logic          done;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    logic [23:0]   exp_q [$];

    // Wire decoder state
    logic          prev_led = 1'b0;
    int            hi_cnt = 0;
    int            since_rise = 0;
    bit            have_rise = 1'b0;
    int            mon_bits = 0;
    logic [23:0]   mon_word = '0;
    int            last_fall_cyc = 0;

    led_chain_driver #(
        .CLOCK_FREQUENCY(20000000),
        .NUM_LEDS       (NL),
        .T0H_NS         (400),
        .T1H_NS         (800),
        .BIT_NS         (1250),
        .LATCH_US       (10)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Wr_En     (wr_en),
        .i_Wr_Addr   (wr_addr),
        .i_Wr_Data   (wr_data),
        .i_Brightness(bright),
        .i_Start     (start),
        .o_Led       (led),
        .o_Ready     (ready),
        .o_Frame_Done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected wire word: components scaled by (B+1)/256, sent as {G,R,B}.
    function automatic logic [23:0] grb(input logic [23:0] rgb, input logic [7:0] b);
        int r, g, bl;
        r  = (int'(rgb[23:16]) * (int'(b) + 1)) / 256;
        g  = (int'(rgb[15:8])  * (int'(b) + 1)) / 256;
        bl = (int'(rgb[7:0])   * (int'(b) + 1)) / 256;
        return {8'(g), 8'(r), 8'(bl)};
    endfunction

    // Decode o_Led: pulse width gives the bit, rise-to-rise must be one bit period.
    always @(negedge clk) begin
        logic bitv;
        logic [23:0] e;
        if (rst) begin
            prev_led   = 1'b0;
            hi_cnt     = 0;
            since_rise = 0;
            have_rise  = 1'b0;
            mon_bits   = 0;
        end else begin
            since_rise++;
            if (ready) have_rise = 1'b0;
            if (led && !prev_led) begin
                if (have_rise) begin
                    n_cmp++;
                    if (since_rise !== BITC) begin
                        n_bad++;
                        $display("FAIL bit_period: got %0d cycles, want %0d", since_rise, BITC);
                    end
                end
                have_rise  = 1'b1;
                since_rise = 0;
                hi_cnt     = 0;
            end
            if (led) hi_cnt++;
            if (!led && prev_led) begin
                last_fall_cyc = cyc;
                n_cmp++;
                bitv = 1'b0;
                if (hi_cnt == T1H) bitv = 1'b1;
                else if (hi_cnt != T0H) begin
                    n_bad++;
                    $display("FAIL high_width: got %0d cycles, want %0d or %0d", hi_cnt, T0H, T1H);
                end
                mon_word = {mon_word[22:0], bitv};
                mon_bits++;
                if (mon_bits == 24) begin
                    mon_bits = 0;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL led_word: got %06h, none expected", mon_word);
                    end else begin
                        e = exp_q.pop_front();
                        if (mon_word !== e) begin
                            n_bad++;
                            $display("FAIL led_word: got %06h, want %06h", mon_word, e);
                        end
                    end
                end
            end
            prev_led = led;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] b);
        bright = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_drop: got %b, want 0", ready);
        end
    endtask

    task automatic wait_bits(input int n);
        int t = 0;
        while (!(mon_bits >= n && led) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 3000) begin
            n_bad++;
            $display("FAIL wait_bits: got timeout, want bit %0d", n);
        end
    endtask

    // Wait for o_Frame_Done and check latch gap, pulse width, ready and queue.
    task automatic wait_done(input logic [23:0] last_word);
        int t = 0;
        int gap, want_gap;
        while (done !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 5000) begin
            n_bad++;
            $display("FAIL frame_done: got timeout, want pulse");
        end else begin
            gap      = cyc - last_fall_cyc;
            want_gap = (BITC - (last_word[0] ? T1H : T0H)) + LATCH - 1;
            n_cmp++;
            if (gap !== want_gap) begin
                n_bad++;
                $display("FAIL latch_gap: got %0d, want %0d", gap, want_gap);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                n_bad++;
                $display("FAIL after_done: got done=%b ready=%b, want done=0 ready=1", done, ready);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL words_left: got %0d, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bright = 8'hFF; start = 1'b0;
        #1;
        n_cmp++;
        if (led !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got led=%b ready=%b done=%b, want 0 1 0", led, ready, done);
        end
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        logic [23:0] c [3] = '{24'hFF0000, 24'h00FF00, 24'h0000FF};
        for (int i = 0; i < 3; i++) wr(AW'(i), c[i]);
        for (int i = 0; i < 3; i++) exp_q.push_back(grb(c[i], 8'hFF));
        start_frame(8'hFF);
        wait_done(grb(c[2], 8'hFF));
    endtask

    task automatic test_brightness();
        logic [23:0] c [3];
        logic [7:0]  b;
        // 0x80 at B=127 -> 0x40; brightness change mid-frame is ignored.
        for (int i = 0; i < 3; i++) wr(AW'(i), 24'h808080);
        for (int i = 0; i < 3; i++) exp_q.push_back(24'h404040);
        start_frame(8'd127);
        tick(100);
        bright = 8'd0;
        wait_done(24'h404040);
        // B=0 blanks everything.
        for (int i = 0; i < 3; i++) exp_q.push_back(24'h000000);
        start_frame(8'd0);
        wait_done(24'h000000);
        // Random colours and brightness.
        for (int k = 0; k < 2; k++) begin
            b = 8'($urandom_range(0, 255));
            for (int i = 0; i < 3; i++) begin
                c[i] = 24'($urandom);
                wr(AW'(i), c[i]);
                exp_q.push_back(grb(c[i], b));
            end
            start_frame(b);
            wait_done(grb(c[2], b));
        end
    endtask

    task automatic test_start_ignored();
        int highs = 0;
        logic [23:0] c [3] = '{24'h123456, 24'hA5C30F, 24'h0F0F0F};
        for (int i = 0; i < 3; i++) wr(AW'(i), c[i]);
        for (int i = 0; i < 3; i++) exp_q.push_back(grb(c[i], 8'hFF));
        start_frame(8'hFF);
        wait_bits(3);
        while (led) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;   // during LOW
        while (exp_q.size() != 0) @(negedge clk);
        tick(BITC + 20);
        start = 1'b1; @(negedge clk); start = 1'b0;   // during LATCH
        wait_done(grb(c[2], 8'hFF));
        for (int i = 0; i < 60; i++) begin
            if (led || !ready) highs++;
            @(negedge clk);
        end
        n_cmp++;
        if (highs != 0) begin
            n_bad++;
            $display("FAIL extra_frame: got %0d active cycles, want 0", highs);
        end
    endtask

    task automatic test_writes();
        logic [23:0] a = 24'h112233, b = 24'h445566, c = 24'h778899;
        logic [23:0] a2 = 24'hF0E0D0, b2 = 24'h0A0B0C;
        wr(0, a); wr(1, b); wr(2, c);
        exp_q.push_back(grb(a, 8'hFF));
        exp_q.push_back(grb(b2, 8'hFF));
        exp_q.push_back(grb(c, 8'hFF));
        start_frame(8'hFF);
        wait_bits(5);
        wr(1, b2);
        wr(0, a2);
        wr(2'd3, 24'hDEAD00);     // out of range, dropped
        wait_done(grb(c, 8'hFF));
        exp_q.push_back(grb(a2, 8'hFF));
        exp_q.push_back(grb(b2, 8'hFF));
        exp_q.push_back(grb(c, 8'hFF));
        start_frame(8'hFF);
        wait_done(grb(c, 8'hFF));
    endtask

    task automatic test_write_first();
        logic [23:0] y = 24'h3C5AA5;
        wr(0, 24'h000000);
        exp_q.push_back(grb(y, 8'hFF));
        exp_q.push_back(grb(24'h0A0B0C, 8'hFF));
        exp_q.push_back(grb(24'h778899, 8'hFF));
        start_frame(8'hFF);
        wr(0, y);                 // lands in the LOAD cycle of LED 0
        wait_done(grb(24'h778899, 8'hFF));
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        logic [23:0] c = 24'h5A5A5A;
        for (int i = 0; i < 3; i++) wr(AW'(i), c);
        start_frame(8'hFF);
        wait_bits(10);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (led !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: got led=%b ready=%b done=%b, want 0 1 0", led, ready, done);
        end
        tick(4);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (led || done || !ready) bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %0d active cycles, want 0", bad);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(grb(c, 8'hFF));
        start_frame(8'hFF);
        wait_done(grb(c, 8'hFF));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_brightness();
        test_start_ignored();
        test_writes();
        test_write_first();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_chain_driver.md
LED_CHAIN_DRIVER -- requirements
Module: led_chain_driver

Interface
REQ-001 CLOCK_FREQUENCY, default 80000000, i_Clock frequency in Hz.
REQ-002 NUM_LEDS, default 8, LEDs in chain (1..256); ADDR_W = max(1, clog2(NUM_LEDS)).
REQ-003 T0H_NS, default 400, high time of a 0 bit in ns.
REQ-004 T1H_NS, default 800, high time of a 1 bit in ns.
REQ-005 BIT_NS, default 1250, total bit period in ns.
REQ-006 LATCH_US, default 80, low time after frame in us.
REQ-007 i_Clock  input  1  sole clock; all logic on rising edge.
REQ-008 i_Reset  input  1  asynchronous, active-high reset.
REQ-009 i_Wr_En  input  1  colour RAM write strobe, one write per cycle.
REQ-010 i_Wr_Addr  input  ADDR_W  LED index to write.
REQ-011 i_Wr_Data  input  24  colour {R[23:16], G[15:8], B[7:0]}.
REQ-012 i_Brightness  input  8  global brightness, sampled at frame start.
REQ-013 i_Start  input  1  frame request.
REQ-014 o_Led  output  1  serial data line to first LED.
REQ-015 o_Ready  output  1  high when idle and able to accept i_Start.
REQ-016 o_Frame_Done  output  1  one-cycle pulse at end of latch period.

Function
REQ-017 Cycle counts SHALL be derived at elaboration: Nx = CLOCK_FREQUENCY*x_NS/1e9, truncated; N_LATCH = CLOCK_FREQUENCY/1e6*LATCH_US (80 MHz: T0H=32, T1H=64, BIT=100, LATCH=6400).
REQ-018 State machine SHALL have states IDLE, LOAD, HIGH, LOW, LATCH.
REQ-019 IDLE: o_Ready=1, o_Led=0; i_Start=1 -> LOAD next cycle, o_Ready=0 same edge, i_Brightness latched, LED index=0.
REQ-020 i_Start outside IDLE SHALL be ignored (no queuing).
REQ-021 LOAD (1 cycle): read RAM[index], scale each component c' = (c*(B+1))>>8 (B=255 gives identity, B=0 gives 0), reorder to shift word {G,R,B}, bit counter=23 -> HIGH.
REQ-022 HIGH: o_Led=1 for T1H cycles if current bit=1, else T0H cycles -> LOW.
REQ-023 LOW: o_Led=0 for remaining BIT-THx cycles; then next bit MSB-first; after bit 0, index+1 -> LOAD, or -> LATCH after index NUM_LEDS-1.
REQ-024 LOAD cycle SHALL be absorbed into preceding LOW period so bit period is exactly BIT cycles across LED boundaries; frame high-bit edges SHALL be periodic at BIT.
REQ-025 LATCH: o_Led=0 for N_LATCH cycles; o_Frame_Done=1 on last cycle; -> IDLE with o_Ready=1 next cycle.
REQ-026 Writes SHALL be accepted in all states; write to index not yet loaded in current frame appears in that frame; write to already-loaded index appears next frame.
REQ-027 i_Wr_Addr >= NUM_LEDS SHALL be ignored with no state change.
REQ-028 Write and LOAD to same address in same cycle: LOAD SHALL get the new data (write-first).
REQ-029 i_Brightness changes mid-frame SHALL not affect the frame in progress.
REQ-030 Scaling multiply SHALL be 8x9 bits, 17-bit product, upper 8 bits kept; no rounding.

Reset
REQ-031 i_Reset SHALL immediately force IDLE, o_Led=0, o_Ready=1, o_Frame_Done=0, counters 0, latched brightness 255.
REQ-032 Reset mid-frame SHALL abort transmission; colour RAM contents need not be reset (RAM-inferable), frame restarts only on new i_Start.

Verification
REQ-033 Defaults, RAM[0]=24'hFF0000, B=255, start -> first 8 bits (G=00) high 32 cycles, next 8 (R=FF) high 64, period 100.
REQ-034 NUM_LEDS=2, RAM={24'h00FF00,24'h0000FF}, start -> 48 bits, boundary gap 100 cycles, then 6400 low, o_Frame_Done one pulse, o_Ready next cycle.
REQ-035 RAM[0]=24'h808080, B=127 -> each component 8'h40 on wire.
REQ-036 i_Start pulsed during LOW and LATCH -> ignored, exactly one frame sent.
REQ-037 Write RAM[1] during LED0 bits -> new value on wire; write RAM[0] same time -> old value; write addr 8 with NUM_LEDS=8 -> no effect.
REQ-038 Assert i_Reset during bit 10 of LED 0 -> o_Led=0 asynchronously, o_Ready=1, no o_Frame_Done; new start sends full frame.
